// File: rtl/id_stage_fwd_pipe_pkg.sv
// Shared decode constants for the ID stage: MIPS32 opcode/function fields,
// aluop and alusel encodings. Imported by id_stage_fwd_pipe and fwd_mux.
package id_stage_fwd_pipe_pkg;

  // Primary opcode field inst[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  // SPECIAL function field inst[5:0]
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  typedef enum logic [7:0] {
    ALUOP_NOP  = 8'b00000000,
    ALUOP_SRL  = 8'b00000010,
    ALUOP_SRA  = 8'b00000011,
    ALUOP_SLLV = 8'b00000100,
    ALUOP_SRLV = 8'b00000110,
    ALUOP_SRAV = 8'b00000111,
    ALUOP_AND  = 8'b00100100,
    ALUOP_OR   = 8'b00100101,
    ALUOP_XOR  = 8'b00100110,
    ALUOP_NOR  = 8'b00100111,
    ALUOP_LUI  = 8'b01011100,
    ALUOP_SLL  = 8'b01111100
  } aluop_e;

  typedef enum logic [2:0] {
    ALUSEL_NOP   = 3'b000,
    ALUSEL_LOGIC = 3'b001,
    ALUSEL_SHIFT = 3'b010
  } alusel_e;

endpackage

// File: rtl/id_stage_fwd_pipe_fwd_mux.sv
// fwd_mux: NUM_FWD-way priority operand forward select for one GPR read port.
//  addr_i        GPR address being read
//  gpr_data_i    data from the register file
//  fwd_wreg_i    per-source write enable
//  fwd_load_i    per-source "data not yet available"
//  fwd_wd_i      per-source destination, source k at [k*REG_AW +: REG_AW]
//  fwd_wdata_i   per-source write data, same packing
//  data_o        selected operand (lowest matching source, else GPR)
//  load_hit_o    winning source still has a load in flight
module fwd_mux
  import id_stage_fwd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]         gpr_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD-1:0]        fwd_load_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      load_hit_o
);

  logic found;

  // $0 is never forwarded: it always reads as the register file value.
  always_comb begin
    found      = 1'b0;
    data_o     = gpr_data_i;
    load_hit_o = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!found && fwd_wreg_i[k] && (addr_i != '0) &&
          (fwd_wd_i[k*REG_AW +: REG_AW] == addr_i)) begin
        found      = 1'b1;
        data_o     = fwd_wdata_i[k*DATA_W +: DATA_W];
        load_hit_o = fwd_load_i[k];
      end
    end
  end

endmodule

// File: rtl/id_stage_fwd_pipe.sv
// id_stage_fwd_pipe: MIPS32 logic/shift decode with operand forwarding,
// load-use stall detection and a registered ID/EX stage with valid/ready.
//  clk, rst              clock; synchronous active-high reset
//  inst_valid_i/inst_i   instruction from IF/ID; id_ready_o = consumed
//  reg{1,2}_read_o/addr  combinational GPR read port control
//  reg{1,2}_data_i       GPR read data
//  fwd_*_i               NUM_FWD write-back sources (0 = youngest)
//  flush_i, ex_ready_i   ID/EX kill and downstream ready
//  ex_*_o                registered ID/EX contents
//  stall_req_o           load-use stall request (comb)
module id_stage_fwd_pipe
  import id_stage_fwd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid_i,
  input  logic [31:0]               inst_i,
  output logic                      id_ready_o,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD-1:0]        fwd_load_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      flush_i,
  input  logic                      ex_ready_i,
  output logic                      ex_valid_o,
  output logic [ALUOP_W-1:0]        ex_aluop_o,
  output logic [ALUSEL_W-1:0]       ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [REG_AW-1:0]         ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_inst_inv_o,
  output logic                      stall_req_o
);

  logic [5:0]        op, fn;
  logic [REG_AW-1:0] rs, rt, rd;

  assign op = inst_i[31:26];
  assign fn = inst_i[5:0];
  assign rs = REG_AW'(inst_i[25:21]);
  assign rt = REG_AW'(inst_i[20:16]);
  assign rd = REG_AW'(inst_i[15:11]);

  logic              dec_rd1, dec_rd2, dec_wreg, dec_inv;
  aluop_e            dec_aluop;
  alusel_e           dec_alusel;
  logic [REG_AW-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm;

  always_comb begin
    dec_rd1    = 1'b0;
    dec_rd2    = 1'b0;
    dec_wreg   = 1'b0;
    dec_inv    = 1'b1;
    dec_aluop  = ALUOP_NOP;
    dec_alusel = ALUSEL_NOP;
    dec_wd     = rd;
    dec_imm    = '0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        dec_rd1    = 1'b1;
        dec_wreg   = 1'b1;
        dec_inv    = 1'b0;
        dec_alusel = ALUSEL_LOGIC;
        dec_wd     = rt;
        dec_imm    = DATA_W'(inst_i[15:0]);
        case (op)
          OP_ORI:  dec_aluop = ALUOP_OR;
          OP_ANDI: dec_aluop = ALUOP_AND;
          OP_XORI: dec_aluop = ALUOP_XOR;
          default: dec_aluop = ALUOP_LUI;
        endcase
      end
      OP_PREF: dec_inv = 1'b0;
      OP_SPECIAL: begin
        case (fn)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_rd1    = 1'b1;
            dec_rd2    = 1'b1;
            dec_wreg   = 1'b1;
            dec_inv    = 1'b0;
            dec_alusel = ALUSEL_LOGIC;
            case (fn)
              FN_AND:  dec_aluop = ALUOP_AND;
              FN_OR:   dec_aluop = ALUOP_OR;
              FN_XOR:  dec_aluop = ALUOP_XOR;
              default: dec_aluop = ALUOP_NOR;
            endcase
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            dec_rd1    = 1'b1;
            dec_rd2    = 1'b1;
            dec_wreg   = 1'b1;
            dec_inv    = 1'b0;
            dec_alusel = ALUSEL_SHIFT;
            case (fn)
              FN_SLLV: dec_aluop = ALUOP_SLLV;
              FN_SRLV: dec_aluop = ALUOP_SRLV;
              default: dec_aluop = ALUOP_SRAV;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_rd2    = 1'b1;
            dec_wreg   = 1'b1;
            dec_inv    = 1'b0;
            dec_alusel = ALUSEL_SHIFT;
            dec_imm    = DATA_W'(inst_i[10:6]);
            case (fn)
              FN_SLL:  dec_aluop = ALUOP_SLL;
              FN_SRL:  dec_aluop = ALUOP_SRL;
              default: dec_aluop = ALUOP_SRA;
            endcase
          end
          FN_SYNC: dec_inv = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] fwd1_data, fwd2_data;
  logic              ld1_hit, ld2_hit;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .addr_i      (rs),
    .gpr_data_i  (reg1_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_load_i  (fwd_load_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .data_o      (fwd1_data),
    .load_hit_o  (ld1_hit)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .addr_i      (rt),
    .gpr_data_i  (reg2_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_load_i  (fwd_load_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .data_o      (fwd2_data),
    .load_hit_o  (ld2_hit)
  );

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              stall, adv, issue;

  assign opnd1 = dec_rd1 ? fwd1_data : dec_imm;
  assign opnd2 = dec_rd2 ? fwd2_data : dec_imm;

  // A pending load only matters on a port that is actually read.
  assign stall = inst_valid_i & ((dec_rd1 & ld1_hit) | (dec_rd2 & ld2_hit));
  assign adv   = ~ex_valid_o | ex_ready_i;
  assign issue = inst_valid_i & ~stall;

  assign reg1_read_o = dec_rd1 & ~rst;
  assign reg2_read_o = dec_rd2 & ~rst;
  assign reg1_addr_o = rst ? '0 : rs;
  assign reg2_addr_o = rst ? '0 : rt;
  assign stall_req_o = stall & ~rst;
  assign id_ready_o  = adv & ~stall & ~rst;

  logic                valid_q, valid_d, wreg_q, wreg_d, inv_q, inv_d;
  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [ALUSEL_W-1:0] alusel_q, alusel_d;
  logic [DATA_W-1:0]   reg1_q, reg1_d, reg2_q, reg2_d;
  logic [REG_AW-1:0]   wd_q, wd_d;

  // Flush only clears the qualifying bits; payload may stay stale.
  always_comb begin
    valid_d  = valid_q;
    wreg_d   = wreg_q;
    inv_d    = inv_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    wd_d     = wd_q;
    if (flush_i) begin
      valid_d = 1'b0;
      wreg_d  = 1'b0;
    end else if (adv) begin
      if (issue) begin
        valid_d  = 1'b1;
        wreg_d   = dec_wreg;
        inv_d    = dec_inv;
        aluop_d  = ALUOP_W'(dec_aluop);
        alusel_d = ALUSEL_W'(dec_alusel);
        reg1_d   = opnd1;
        reg2_d   = opnd2;
        wd_d     = dec_wd;
      end else begin
        valid_d  = 1'b0;
        wreg_d   = 1'b0;
        inv_d    = 1'b0;
        aluop_d  = ALUOP_W'(ALUOP_NOP);
        alusel_d = ALUSEL_W'(ALUSEL_NOP);
        reg1_d   = '0;
        reg2_d   = '0;
        wd_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      inv_q    <= 1'b0;
      aluop_q  <= '0;
      alusel_q <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      wreg_q   <= wreg_d;
      inv_q    <= inv_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wd_q     <= wd_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_wreg_o     = wreg_q;
  assign ex_inst_inv_o = inv_q;
  assign ex_aluop_o    = aluop_q;
  assign ex_alusel_o   = alusel_q;
  assign ex_reg1_o     = reg1_q;
  assign ex_reg2_o     = reg2_q;
  assign ex_wd_o       = wd_q;

endmodule

// File: tb/tb_id_stage_fwd_pipe.sv
// Self-checking bench for id_stage_fwd_pipe: directed scenarios followed by
// randomized traffic compared against a behavioural model of the ID stage.
module tb_id_stage_fwd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic        id_ready_o, reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i, fwd_load_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        flush_i, ex_ready_i;
  logic        ex_valid_o, ex_wreg_o, ex_inst_inv_o, stall_req_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o;
  logic [4:0]  ex_wd_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] gpr [32];

  id_stage_fwd_pipe #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2), .ALUOP_W(8), .ALUSEL_W(3)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
    .id_ready_o(id_ready_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_load_i(fwd_load_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
    .ex_wreg_o(ex_wreg_o), .ex_inst_inv_o(ex_inst_inv_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register file responds to the instruction's rs/rt fields.
  task automatic drive_gpr();
    reg1_data_i = gpr[inst_i[25:21]];
    reg2_data_i = gpr[inst_i[20:16]];
  endtask

  task automatic idle_inputs();
    rst = 1'b0; inst_valid_i = 1'b0; inst_i = '0;
    fwd_wreg_i = '0; fwd_load_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b1;
    drive_gpr();
  endtask

  // Reference decode: ISA-level meaning of each supported instruction.
  function automatic void ref_decode(input logic [31:0] in,
      output logic rd1, output logic rd2, output logic wreg, output logic inv,
      output logic [7:0] aop, output logic [2:0] sel, output logic [4:0] wd,
      output logic [31:0] imm);
    rd1 = 0; rd2 = 0; wreg = 0; inv = 1; aop = 8'h00; sel = 3'd0;
    wd = in[15:11]; imm = 32'h0;
    case (in[31:26])
      6'h0d, 6'h0c, 6'h0e, 6'h0f: begin
        rd1 = 1; wreg = 1; inv = 0; sel = 3'd1; wd = in[20:16];
        imm = {16'h0, in[15:0]};
        aop = (in[31:26] == 6'h0d) ? 8'h25 : (in[31:26] == 6'h0c) ? 8'h24 :
              (in[31:26] == 6'h0e) ? 8'h26 : 8'h5c;
      end
      6'h33: inv = 0;
      6'h00: begin
        case (in[5:0])
          6'h24: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd1; aop = 8'h24; end
          6'h25: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd1; aop = 8'h25; end
          6'h26: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd1; aop = 8'h26; end
          6'h27: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd1; aop = 8'h27; end
          6'h04: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd2; aop = 8'h04; end
          6'h06: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd2; aop = 8'h06; end
          6'h07: begin rd1 = 1; rd2 = 1; wreg = 1; inv = 0; sel = 3'd2; aop = 8'h07; end
          6'h00: begin rd2 = 1; wreg = 1; inv = 0; sel = 3'd2; aop = 8'h7c; imm = {27'h0, in[10:6]}; end
          6'h02: begin rd2 = 1; wreg = 1; inv = 0; sel = 3'd2; aop = 8'h02; imm = {27'h0, in[10:6]}; end
          6'h03: begin rd2 = 1; wreg = 1; inv = 0; sel = 3'd2; aop = 8'h03; imm = {27'h0, in[10:6]}; end
          6'h0f: inv = 0;
          default: ;
        endcase
      end
      default: ;
    endcase
  endfunction

  // Reference forwarding: youngest source overrides older ones; $0 never forwards.
  function automatic void ref_fwd(input logic [4:0] a, output logic [31:0] d, output logic ld);
    d = gpr[a]; ld = 0;
    if (a != 0)
      for (int k = 1; k >= 0; k--)
        if (fwd_wreg_i[k] && fwd_wd_i[k*5 +: 5] == a) begin
          d = fwd_wdata_i[k*32 +: 32]; ld = fwd_load_i[k];
        end
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] iops [4];
    logic [5:0] fns [10];
    logic [4:0] rs, rt, rd;
    int unsigned sel;
    iops = '{6'h0d, 6'h0c, 6'h0e, 6'h0f};
    fns  = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03};
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 7));
    sel = $urandom_range(0, 19);
    if (sel < 4)        return {iops[sel], rs, rt, 16'($urandom)};
    else if (sel == 4)  return {6'h33, rs, rt, 16'($urandom)};
    else if (sel < 15)  return {6'h00, rs, rt, rd, 5'($urandom), fns[sel-5]};
    else if (sel == 15) return {6'h00, 20'h0, 6'h0f};
    else if (sel == 16) return {6'h00, rs, rt, rd, 5'h0, 6'h2a};
    else                return $urandom;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; inst_valid_i = 1'b1; inst_i = 32'h00221825;
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_load_i = 2'b01; drive_gpr();
    tick(); tick();
    checks++;
    if ({reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, id_ready_o, stall_req_o} !== 14'h0) begin
      errors++;
      $display("FAIL reset_comb: got %h want 0",
               {reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, id_ready_o, stall_req_o});
    end
    checks++;
    if ({ex_valid_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_inv_o} !== '0) begin
      errors++;
      $display("FAIL reset_ex: valid=%b aluop=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b inv=%b want all 0",
               ex_valid_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_inv_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ori();
    idle_inputs();
    inst_valid_i = 1'b1; inst_i = 32'h34011100; drive_gpr();
    #1;
    checks++;
    if ({reg1_read_o, reg2_read_o, reg1_addr_o, id_ready_o, stall_req_o} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ori_comb: rd1=%b rd2=%b a1=%0d ready=%b stall=%b want 1 0 0 1 0",
               reg1_read_o, reg2_read_o, reg1_addr_o, id_ready_o, stall_req_o);
    end
    tick();
    checks++;
    if ({ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o, ex_alusel_o, ex_inst_inv_o} !==
        {1'b1, 32'h0, 32'h00001100, 5'd1, 1'b1, 8'h25, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL ori_ex: valid=%b r1=%h r2=%h wd=%0d wreg=%b aluop=%h sel=%0d inv=%b want 1 0 1100 1 1 25 1 0",
               ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o, ex_alusel_o, ex_inst_inv_o);
    end
  endtask

  task automatic test_or_fwd();
    idle_inputs();
    inst_valid_i = 1'b1; inst_i = 32'h00221825; drive_gpr();
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd2, 5'd1}; fwd_wdata_i = {32'h00005555, 32'hAAAA0000};
    tick();
    checks++;
    if ({ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_aluop_o} !== {1'b1, 32'hAAAA0000, 32'h00005555, 5'd3, 8'h25}) begin
      errors++;
      $display("FAIL or_fwd: valid=%b r1=%h r2=%h wd=%0d aluop=%h want 1 aaaa0000 00005555 3 25",
               ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_aluop_o);
    end
    fwd_wd_i = {5'd1, 5'd1};
    tick();
    checks++;
    if ({ex_reg1_o, ex_reg2_o} !== {32'hAAAA0000, gpr[2]}) begin
      errors++;
      $display("FAIL or_fwd_prio: r1=%h r2=%h want aaaa0000 %h", ex_reg1_o, ex_reg2_o, gpr[2]);
    end
  endtask

  task automatic test_zero_fwd();
    idle_inputs();
    inst_valid_i = 1'b1; inst_i = 32'h34011100; drive_gpr();
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'hFFFFFFFF};
    tick();
    checks++;
    if ({ex_valid_o, ex_reg1_o} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL zero_fwd: valid=%b r1=%h want 1 00000000", ex_valid_o, ex_reg1_o);
    end
  endtask

  task automatic test_sll();
    idle_inputs();
    gpr[1] = 32'h3;
    inst_valid_i = 1'b1; inst_i = 32'h00011100; drive_gpr();
    #1;
    checks++;
    if ({reg1_read_o, reg2_read_o, reg2_addr_o} !== {1'b0, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL sll_comb: rd1=%b rd2=%b a2=%0d want 0 1 1", reg1_read_o, reg2_read_o, reg2_addr_o);
    end
    tick();
    checks++;
    if ({ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_aluop_o, ex_alusel_o} !==
        {1'b1, 32'h4, 32'h3, 5'd2, 8'h7c, 3'd2}) begin
      errors++;
      $display("FAIL sll_ex: valid=%b r1=%h r2=%h wd=%0d aluop=%h sel=%0d want 1 4 3 2 7c 2",
               ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_aluop_o, ex_alusel_o);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    inst_valid_i = 1'b1; inst_i = 32'h00221825; drive_gpr();
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_wdata_i = {32'h0, 32'h12345678}; fwd_load_i = 2'b01;
    #1;
    checks++;
    if ({stall_req_o, id_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b ready=%b want 1 0", stall_req_o, id_ready_o);
    end
    tick();
    checks++;
    if ({ex_valid_o, ex_wreg_o, ex_aluop_o, ex_alusel_o} !== 13'h0) begin
      errors++;
      $display("FAIL load_use_bubble: valid=%b wreg=%b aluop=%h sel=%0d want 0 0 00 0",
               ex_valid_o, ex_wreg_o, ex_aluop_o, ex_alusel_o);
    end
    fwd_load_i = 2'b00;
    #1;
    checks++;
    if ({stall_req_o, id_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL load_use_release: stall=%b ready=%b want 0 1", stall_req_o, id_ready_o);
    end
    tick();
    checks++;
    if ({ex_valid_o, ex_reg1_o} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL load_use_issue: valid=%b r1=%h want 1 12345678", ex_valid_o, ex_reg1_o);
    end
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_load_i = 2'b10;
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL load_shadowed: stall=%b want 0", stall_req_o);
    end
    inst_i = 32'h00221100; fwd_wreg_i = 2'b01; fwd_load_i = 2'b01; drive_gpr();
    #1;
    checks++;
    if ({stall_req_o, id_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL load_unread_port: stall=%b ready=%b want 0 1", stall_req_o, id_ready_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    inst_valid_i = 1'b1; inst_i = 32'h34011100; drive_gpr();
    tick();
    ex_ready_i = 1'b0; inst_i = 32'h00221825; drive_gpr();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (id_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready: cycle %0d ready=%b want 0", c, id_ready_o);
      end
      tick();
      checks++;
      if ({ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o, ex_alusel_o} !==
          {1'b1, 32'h0, 32'h00001100, 5'd1, 1'b1, 8'h25, 3'd1}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b r1=%h r2=%h wd=%0d wreg=%b aluop=%h want 1 0 1100 1 1 25",
                 c, ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o);
      end
    end
    flush_i = 1'b1;
    tick();
    checks++;
    if ({ex_valid_o, ex_wreg_o} !== 2'b00) begin
      errors++;
      $display("FAIL bp_flush: valid=%b wreg=%b want 0 0", ex_valid_o, ex_wreg_o);
    end
    flush_i = 1'b0; ex_ready_i = 1'b1;
    tick();
    ex_ready_i = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if ({ex_valid_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_inv_o} !== '0) begin
      errors++;
      $display("FAIL bp_reset: valid=%b aluop=%h r1=%h r2=%h wd=%0d wreg=%b want all 0",
               ex_valid_o, ex_aluop_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic rd1, rd2, wreg, inv, l1, l2, stall_e, adv;
    logic [7:0] aop; logic [2:0] sel; logic [4:0] wd; logic [31:0] imm, d1, d2;
    logic e_valid = 0, e_wreg = 0, e_inv = 0;
    logic [7:0] e_op = 0; logic [2:0] e_sel = 0; logic [31:0] e_r1 = 0, e_r2 = 0; logic [4:0] e_wd = 0;
    bit ops_k = 1, data_k = 1;
    logic [13:0] comb_e;
    for (int n = 0; n < 800; n++) begin
      rst = (n == 0) || ($urandom_range(0, 49) == 0);
      inst_valid_i = ($urandom_range(0, 9) < 8);
      inst_i = rand_inst();
      fwd_wreg_i = 2'($urandom);
      fwd_load_i = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      fwd_wd_i = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_wdata_i = {$urandom, $urandom};
      flush_i = ($urandom_range(0, 9) == 0);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      drive_gpr();
      #1;
      ref_decode(inst_i, rd1, rd2, wreg, inv, aop, sel, wd, imm);
      ref_fwd(inst_i[25:21], d1, l1);
      ref_fwd(inst_i[20:16], d2, l2);
      stall_e = inst_valid_i && ((rd1 && l1) || (rd2 && l2));
      adv = !e_valid || ex_ready_i;
      comb_e = rst ? 14'h0 : {stall_e, adv && !stall_e, rd1, rd2, inst_i[25:21], inst_i[20:16]};
      checks++;
      if ({stall_req_o, id_ready_o, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o} !== comb_e) begin
        errors++;
        $display("FAIL rand_comb: n=%0d inst=%h got %h want %h", n, inst_i,
                 {stall_req_o, id_ready_o, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o}, comb_e);
      end
      if (rst) begin
        e_valid = 0; e_wreg = 0; e_inv = 0; e_op = 0; e_sel = 0; e_r1 = 0; e_r2 = 0; e_wd = 0;
        ops_k = 1; data_k = 1;
      end else if (flush_i) begin
        e_valid = 0; e_wreg = 0; ops_k = 0; data_k = 0;
      end else if (adv) begin
        if (inst_valid_i && !stall_e) begin
          e_valid = 1; e_wreg = wreg; e_inv = inv; e_op = aop; e_sel = sel; e_wd = wd;
          e_r1 = rd1 ? d1 : imm; e_r2 = rd2 ? d2 : imm;
          ops_k = 1; data_k = 1;
        end else begin
          e_valid = 0; e_wreg = 0; e_op = 0; e_sel = 0; ops_k = 1; data_k = 0;
        end
      end
      tick();
      checks++;
      if ({ex_valid_o, ex_wreg_o} !== {e_valid, e_wreg}) begin
        errors++;
        $display("FAIL rand_valid: n=%0d valid/wreg got %b%b want %b%b", n, ex_valid_o, ex_wreg_o, e_valid, e_wreg);
      end
      if (ops_k) begin
        checks++;
        if ({ex_aluop_o, ex_alusel_o} !== {e_op, e_sel}) begin
          errors++;
          $display("FAIL rand_op: n=%0d aluop/sel got %h/%0d want %h/%0d", n, ex_aluop_o, ex_alusel_o, e_op, e_sel);
        end
      end
      if (data_k) begin
        checks++;
        if ({ex_reg1_o, ex_reg2_o, ex_wd_o, ex_inst_inv_o} !== {e_r1, e_r2, e_wd, e_inv}) begin
          errors++;
          $display("FAIL rand_data: n=%0d r1=%h r2=%h wd=%0d inv=%b want %h %h %0d %b", n,
                   ex_reg1_o, ex_reg2_o, ex_wd_o, ex_inst_inv_o, e_r1, e_r2, e_wd, e_inv);
        end
      end
    end
  endtask

  initial begin
    gpr[0] = 32'h0;
    for (int i = 1; i < 32; i++) gpr[i] = $urandom;
    test_reset();
    test_ori();
    test_or_fwd();
    test_zero_fwd();
    test_sll();
    test_load_use();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
